// File: rtl/arb_rr_tout.sv
// N-way bus arbiter: round-robin or fixed-priority selection, per-grant busy
// timeout with sticky TIMEOUT state, delayed release through WAIT and a
// mandatory one-cycle FREE turnaround bubble between owners.
module arb_rr_tout #(
  parameter int N           = 4,
  parameter int TOUT_CYCLES = 3,
  parameter int RR_MODE     = 1,
  parameter int IDW         = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           done,
  input  logic           dly,
  input  logic           tout_clr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           tout,
  output logic [IDW-1:0] tout_id,
  output logic [7:0]     tout_cnt
);

  localparam int CW = $clog2(TOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_BUSY = 3'd1,
    S_WAIT = 3'd2,
    S_FREE = 3'd3,
    S_TOUT = 3'd4
  } state_t;

  state_t         state;
  logic [IDW-1:0] owner;
  logic [IDW-1:0] last_owner;
  logic [CW-1:0]  busy_cnt;
  logic [IDW-1:0] win;

  // Winner select: rotate from last_owner+1 in RR mode, lowest index otherwise.
  // Loops run from the far end so the nearest set request is the last write.
  always_comb begin
    win = '0;
    if (RR_MODE != 0) begin
      for (int i = N; i >= 1; i--) begin
        if (req[(int'(last_owner) + i) % N])
          win = IDW'((int'(last_owner) + i) % N);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req[i]) win = IDW'(i);
      end
    end
  end

  // Grant decode straight from registered state and owner, so an async reset
  // drops it at once.
  for (genvar g = 0; g < N; g++) begin : g_gnt
    assign gnt[g] = ((state == S_BUSY) || (state == S_WAIT)) && (owner == IDW'(g));
  end

  assign tout   = (state == S_TOUT);
  assign gnt_id = owner;

  // Arbitration FSM with owner, busy counter, priority pointer and timeout log.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= '0;
      last_owner <= IDW'(N - 1);
      busy_cnt   <= '0;
      tout_id    <= '0;
      tout_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE, S_FREE: begin
          if (|req) begin
            owner      <= win;
            last_owner <= win;
            busy_cnt   <= '0;
            state      <= S_BUSY;
          end else begin
            state <= S_IDLE;
          end
        end
        S_BUSY: begin
          // done outranks a timeout landing on the same cycle
          if (done) begin
            state <= dly ? S_WAIT : S_FREE;
          end else if (busy_cnt == CW'(TOUT_CYCLES - 1)) begin
            state   <= S_TOUT;
            tout_id <= owner;
            if (tout_cnt != 8'hFF) tout_cnt <= tout_cnt + 8'd1;
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (!dly) state <= S_FREE;
        end
        S_TOUT: begin
          if (tout_clr) state <= dly ? S_WAIT : S_FREE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arb_rr_tout.sv
// Directed bench: one round-robin and one fixed-priority arbiter share the
// stimulus; each step samples outputs 1 time unit after the rising edge.
module tb_arb_rr_tout;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] req = '0;
  logic         done = 1'b0;
  logic         dly = 1'b0;
  logic         tout_clr = 1'b0;

  logic [N-1:0] gnt, gnt_f;
  logic [1:0]   gnt_id, gnt_id_f, tout_id, tout_id_f;
  logic         tout, tout_f;
  logic [7:0]   tout_cnt, tout_cnt_f;

  int checks = 0;
  int errors = 0;

  arb_rr_tout #(.N(N), .TOUT_CYCLES(3), .RR_MODE(1)) dut_rr (
    .clk(clk), .rst(rst), .req(req), .done(done), .dly(dly), .tout_clr(tout_clr),
    .gnt(gnt), .gnt_id(gnt_id), .tout(tout), .tout_id(tout_id), .tout_cnt(tout_cnt)
  );

  arb_rr_tout #(.N(N), .TOUT_CYCLES(3), .RR_MODE(0)) dut_fp (
    .clk(clk), .rst(rst), .req(req), .done(done), .dly(dly), .tout_clr(tout_clr),
    .gnt(gnt_f), .gnt_id(gnt_id_f), .tout(tout_f), .tout_id(tout_id_f), .tout_cnt(tout_cnt_f)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [N-1:0] exp_seq [9];
  logic [N-1:0] exp_fp  [5];
  logic [N-1:0] exp_rr5 [5];

  initial begin
    exp_seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                4'b0000, 4'b1000, 4'b0000, 4'b0001};
    exp_fp  = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0010};
    exp_rr5 = '{4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0010};

    #1 rst = 1'b1;
    #2;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_gnt_id", 32'(gnt_id), 32'h0);
    chk("rst_tout", 32'(tout), 32'h0);
    chk("rst_tout_id", 32'(tout_id), 32'h0);
    chk("rst_tout_cnt", 32'(tout_cnt), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // round-robin 0,1,2,3,0 with FREE bubbles
    req = 4'b1111; done = 1'b1; dly = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("rr_seq%0d", i), 32'(gnt), 32'(exp_seq[i]));
    end
    chk("rr_gnt_id", 32'(gnt_id), 32'h0);
    req = '0;
    step();
    chk("rr_free", 32'(gnt), 32'h0);
    step();
    chk("rr_idle", 32'(gnt), 32'h0);

    // master 2 times out after exactly 3 BUSY cycles; req held is ignored
    req = 4'b0100; done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("to_gnt%0d", i), 32'(gnt), 32'h4);
      chk($sformatf("to_tout%0d", i), 32'(tout), 32'h0);
    end
    step();
    chk("to_gnt_off", 32'(gnt), 32'h0);
    chk("to_tout", 32'(tout), 32'h1);
    chk("to_tout_id", 32'(tout_id), 32'h2);
    chk("to_tout_cnt", 32'(tout_cnt), 32'h1);
    step();
    chk("to_sticky", 32'(tout), 32'h1);
    chk("to_req_ign", 32'(gnt), 32'h0);
    tout_clr = 1'b1; req = '0;
    step();
    tout_clr = 1'b0;
    chk("to_clr_tout", 32'(tout), 32'h0);
    chk("to_clr_gnt", 32'(gnt), 32'h0);
    step();
    chk("to_idle_gnt", 32'(gnt), 32'h0);

    // done on the would-be timeout cycle wins
    req = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("race_gnt%0d", i), 32'(gnt), 32'h1);
    end
    done = 1'b1; req = '0;
    step();
    done = 1'b0;
    chk("race_gnt_off", 32'(gnt), 32'h0);
    chk("race_tout", 32'(tout), 32'h0);
    chk("race_cnt", 32'(tout_cnt), 32'h1);

    // done with dly: 4 WAIT cycles holding grant, no timeout there
    req = 4'b1000;
    step();
    chk("dly_busy", 32'(gnt), 32'h8);
    done = 1'b1; dly = 1'b1; req = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      done = 1'b0;
      chk($sformatf("dly_wait%0d", i), 32'(gnt), 32'h8);
      chk($sformatf("dly_tout%0d", i), 32'(tout), 32'h0);
    end
    dly = 1'b0;
    step();
    chk("dly_free", 32'(gnt), 32'h0);
    chk("dly_gnt_id", 32'(gnt_id), 32'h3);

    // fixed priority starves master 3; round-robin alternates
    do_reset();
    req = 4'b1010; done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("fp_seq%0d", i), 32'(gnt_f), 32'(exp_fp[i]));
      chk($sformatf("rr2_seq%0d", i), 32'(gnt), 32'(exp_rr5[i]));
    end

    // async reset mid-BUSY
    do_reset();
    req = 4'b0100; done = 1'b0;
    step();
    chk("mb_busy", 32'(gnt), 32'h4);
    rst = 1'b1;
    #1;
    chk("mb_rst_gnt", 32'(gnt), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    req = 4'b0110;
    step();
    chk("mb_next", 32'(gnt), 32'h2);

    // async reset mid-TIMEOUT
    do_reset();
    req = 4'b0100;
    for (int i = 0; i < 4; i++) step();
    chk("mt_tout", 32'(tout), 32'h1);
    rst = 1'b1;
    #1;
    chk("mt_rst_tout", 32'(tout), 32'h0);
    chk("mt_rst_gnt", 32'(gnt), 32'h0);
    chk("mt_rst_cnt", 32'(tout_cnt), 32'h0);
    chk("mt_rst_id", 32'(tout_id), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1100;
    step();
    chk("mt_next", 32'(gnt), 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
